// File: rtl/clock_calendar_gen.sv
// Clock/calendar core: clock divider to a seconds tick, time of day, Gregorian date, validated set.
// Optional alarm compare is built only when CLOCK_CAL_ALARM_EN is defined.
module clock_calendar_gen #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int RESET_YEAR  = 2022
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  speed,
  input  logic        pause,
  input  logic        mode_12h,
  input  logic        set_valid,
  output logic        set_ready,
  input  logic [5:0]  set_sec,
  input  logic [5:0]  set_min,
  input  logic [4:0]  set_hour,
  input  logic [4:0]  set_day,
  input  logic [3:0]  set_month,
  input  logic [13:0] set_year,
  output logic        set_err,
  output logic [5:0]  sec,
  output logic [5:0]  min,
  output logic [4:0]  hour,
  output logic [4:0]  disp_hour,
  output logic        pm,
  output logic [4:0]  day,
  output logic [3:0]  month,
  output logic [13:0] year,
  output logic        tick,
  output logic        end_of_day
`ifdef CLOCK_CAL_ALARM_EN
  ,
  input  logic [4:0]  alarm_hour,
  input  logic [5:0]  alarm_min,
  input  logic        alarm_arm,
  output logic        alarm
`endif
);

  localparam int CNT_W = $clog2(CLK_FREQ_HZ);

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [13:0] y);
    logic leap;
    leap = (((y % 14'd4) == 14'd0) && ((y % 14'd100) != 14'd0)) || ((y % 14'd400) == 14'd0);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:                    days_in_month = leap ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

  // Terminal count per speed setting: CLK_FREQ_HZ / 10**speed - 1.
  logic [CNT_W-1:0] div_m1_tab [4];
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_div
      assign div_m1_tab[gi] = CNT_W'(CLK_FREQ_HZ / (10 ** gi) - 1);
    end
  endgenerate

  logic [CNT_W-1:0] div_cnt_reg;
  logic [1:0]       speed_reg;
  logic [CNT_W-1:0] div_m1;
  logic             speed_change;
  logic             cnt_at_top;
  logic             set_accept;
  logic             set_ok;
  logic             set_load;
  logic             tick_fire;

  assign div_m1       = div_m1_tab[speed];
  assign speed_change = (speed != speed_reg);
  assign cnt_at_top   = (div_cnt_reg == div_m1);
  assign set_accept   = set_valid && set_ready;
  assign set_ok       = (set_sec <= 6'd59) && (set_min <= 6'd59) && (set_hour <= 5'd23) &&
                        (set_month >= 4'd1) && (set_month <= 4'd12) && (set_year <= 14'd9999) &&
                        (set_day != 5'd0) && (set_day <= days_in_month(set_month, set_year));
  assign set_load     = set_accept && set_ok;
  // A valid set discards a coincident tick; a speed change restarts the count without ticking.
  assign tick_fire    = !set_load && !speed_change && !pause && cnt_at_top;

  // Whole carry chain resolved combinationally so every field updates on one edge.
  logic        sec_wrap, min_wrap, hour_wrap, day_wrap, month_wrap;
  logic [4:0]  dim_cur;
  logic [5:0]  sec_next, min_next;
  logic [4:0]  hour_next, day_next;
  logic [3:0]  month_next;
  logic [13:0] year_next;

  always_comb begin
    dim_cur    = days_in_month(month, year);
    sec_wrap   = (sec >= 6'd59);
    min_wrap   = sec_wrap && (min >= 6'd59);
    hour_wrap  = min_wrap && (hour >= 5'd23);
    day_wrap   = hour_wrap && (day >= dim_cur);
    month_wrap = day_wrap && (month >= 4'd12);
    sec_next   = sec_wrap ? 6'd0 : sec + 6'd1;
    min_next   = min;
    if (sec_wrap) min_next = (min >= 6'd59) ? 6'd0 : min + 6'd1;
    hour_next  = hour;
    if (min_wrap) hour_next = (hour >= 5'd23) ? 5'd0 : hour + 5'd1;
    day_next   = day;
    if (hour_wrap) day_next = (day >= dim_cur) ? 5'd1 : day + 5'd1;
    month_next = month;
    if (day_wrap) month_next = (month >= 4'd12) ? 4'd1 : month + 4'd1;
    year_next  = year;
    if (month_wrap) year_next = (year >= 14'd9999) ? 14'd0 : year + 14'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      speed_reg   <= speed;
      div_cnt_reg <= '0;
      set_ready   <= 1'b0;
      set_err     <= 1'b0;
      tick        <= 1'b0;
      end_of_day  <= 1'b0;
      sec         <= 6'd0;
      min         <= 6'd0;
      hour        <= 5'd0;
      pm          <= 1'b0;
      day         <= 5'd1;
      month       <= 4'd1;
      year        <= 14'(RESET_YEAR);
    end else begin
      speed_reg  <= speed;
      set_ready  <= 1'b1;
      set_err    <= set_accept && !set_ok;
      tick       <= tick_fire;
      end_of_day <= tick_fire && hour_wrap;
      if (set_load) begin
        div_cnt_reg <= '0;
        sec         <= set_sec;
        min         <= set_min;
        hour        <= set_hour;
        pm          <= (set_hour >= 5'd12);
        day         <= set_day;
        month       <= set_month;
        year        <= set_year;
      end else if (speed_change) begin
        div_cnt_reg <= '0;
      end else if (!pause) begin
        if (cnt_at_top) begin
          div_cnt_reg <= '0;
          sec         <= sec_next;
          min         <= min_next;
          hour        <= hour_next;
          pm          <= (hour_next >= 5'd12);
          day         <= day_next;
          month       <= month_next;
          year        <= year_next;
        end else begin
          div_cnt_reg <= div_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    disp_hour = hour;
    if (mode_12h) begin
      if (hour == 5'd0 || hour == 5'd12) disp_hour = 5'd12;
      else if (hour > 5'd12)             disp_hour = hour - 5'd12;
    end
  end

`ifdef CLOCK_CAL_ALARM_EN
  // Only a tick can raise the alarm; a set landing on the alarm time stays silent.
  always_ff @(posedge clk) begin
    if (!reset) begin
      alarm <= 1'b0;
    end else begin
      alarm <= tick_fire && alarm_arm && (hour_next == alarm_hour) &&
               (min_next == alarm_min) && (sec_next == 6'd0);
    end
  end
`endif

endmodule
